auto_parkcalc_hls_deadlock_report_unit: RTL and testbench
=========================================================

// Module: auto_parkcalc_hls_deadlock_report_unit
// PURPOSE
//   Consumes the 1-bit 'block' outputs of the per-instance HLS deadlock
//   monitors and confirms a deadlock only when one stays asserted for
//   THRESHOLD consecutive cycles. On confirmation it latches the monitor index
//   and a timestamp, then reports once over a valid/ready handshake. A sticky
//   flag stays set until software clears it.
// PARAMETERS
//   NUM_MON   2     number of monitor block inputs (>=1)
//   IDX_W     1     width of monitor index, = max(1, clog2(NUM_MON))
//   CNT_W     16    persistence counter width
//   THRESHOLD 1000  consecutive blocked cycles to confirm (1 .. 2^CNT_W-1)
//   TS_W      32    free-running cycle timestamp width
// PORTS
//   clock             in   1        sole clock, rising edge
//   reset_n           in   1        synchronous, active-low reset
//   block_sigs        in   NUM_MON  monitor block outputs, bit i = monitor i
//   clear             in   1        one-cycle pulse, drops sticky flag / aborts arm
//   report_valid      out  1        report payload valid
//   report_ready      in   1        consumer accepts report
//   report_idx        out  IDX_W    index of the confirmed monitor
//   report_ts         out  TS_W     timestamp at confirmation
//   deadlock_detected out  1        sticky: deadlock confirmed, not yet cleared
//   state_dbg         out  2        current FSM state encoding
// BEHAVIOUR
//   Reset (reset_n=0 at a rising edge): all outputs 0, state IDLE, persist
//     count 0, timestamp counter 0. No other reset path.
//   Timestamp counter: +1 every cycle, wraps at 2^TS_W silently.
//   Candidate: the lowest-index set bit of block_sigs (fixed priority).
//   FSM states and encodings: IDLE=0, ARMED=1, REPORT=2, HOLD=3.
//   IDLE: if any bit is set, latch cand, set count=1, go ARMED.
//     If THRESHOLD==1, go straight to REPORT instead.
//   ARMED, block_sigs[cand]=1: count+1.
//     Reaching THRESHOLD on this edge: go REPORT.
//   ARMED, block_sigs[cand]=0:
//     other bits set: re-latch new lowest cand, count=1, stay ARMED.
//     no bits set: count=0, go IDLE.
//   ARMED, clear=1: takes priority. Go IDLE with count=0, even if a bit is set.
//   Entering REPORT: report_idx=cand and report_ts=current timestamp, both on
//     the same edge. report_valid=1 and deadlock_detected=1 from the next cycle.
//   REPORT: report_valid stays high; idx/ts stay stable until accepted.
//     Inputs (block_sigs, clear) are ignored.
//     report_valid & report_ready at an edge: go HOLD; report_valid=0 next cycle.
//   HOLD: deadlock_detected=1, report_idx/report_ts held, block_sigs ignored.
//     clear=1: go IDLE; deadlock_detected, report_idx and report_ts go to 0.
//   Latency: a bit high in cycles 0..T-1 (T=THRESHOLD) gives report_valid=1 in
//     cycle T. Exactly one report per confirmed deadlock; never a second until
//     cleared.
//   count never exceeds THRESHOLD. Dropout for even one cycle restarts counting.
// TESTING (NUM_MON=2, THRESHOLD=4)
//   block_sigs=01 for 4 cycles, ready=1
//     -> valid for 1 cycle at cycle 4, idx=0, ts=3, then HOLD with detected=1.
//   block_sigs=10 for 3 cycles, 00 for 1 cycle, 10 for 4 cycles
//     -> no report until 4 unbroken cycles; then idx=1.
//   block_sigs=11 for 2 cycles, then 10
//     -> cand 0 drops, cand re-latched to 1 with count=1; report after 4 more
//        cycles of 10, idx=1.
//   Confirm while report_ready=0 for 5 cycles
//     -> valid, idx and ts held stable; clear pulse ignored; HOLD after ready.
//   clear while ARMED at count=3 -> IDLE, no report, even with block_sigs=01.
//     In HOLD: clear -> detected=0. reset_n=0 mid-REPORT -> all outputs 0.

Source files
------------

// File: rtl/auto_parkcalc_hls_deadlock_report_unit.sv
// Deadlock report unit: confirms a persistently blocked HLS monitor, latches its
// index and a timestamp, reports once over valid/ready and keeps a sticky flag.
module auto_parkcalc_hls_deadlock_report_unit #(
    parameter int NUM_MON   = 2,
    parameter int IDX_W     = 1,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1000,
    parameter int TS_W      = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [TS_W-1:0]    report_ts,
    output logic               deadlock_detected,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPORT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TS_W-1:0]   rts_q, rts_d;
    logic [TS_W-1:0]   ts_q;
    logic [IDX_W-1:0]  lowIdx;
    logic              anyBlock;

    // Fixed priority: scanning downward leaves the lowest set bit's index.
    always_comb begin
        lowIdx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (block_sigs[i]) begin
                lowIdx = IDX_W'(i);
            end
        end
    end

    assign anyBlock = |block_sigs;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        count_d = count_q;
        idx_d   = idx_q;
        rts_d   = rts_q;
        case (state_q)
            IDLE: begin
                if (anyBlock) begin
                    cand_d  = lowIdx;
                    count_d = CNT_ONE;
                    if (THRESHOLD == 1) begin
                        state_d = REPORT;
                        idx_d   = lowIdx;
                        rts_d   = ts_q;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (block_sigs[cand_q]) begin
                    count_d = count_q + CNT_ONE;
                    if (count_q + CNT_ONE == CNT_THR) begin
                        state_d = REPORT;
                        idx_d   = cand_q;
                        rts_d   = ts_q;
                    end
                end else if (anyBlock) begin
                    cand_d  = lowIdx;
                    count_d = CNT_ONE;
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            REPORT: begin
                if (report_ready) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = '0;
                    idx_d   = '0;
                    rts_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            rts_q   <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            rts_q   <= rts_d;
            ts_q    <= ts_q + TS_W'(1);
        end
    end

    // Valid and the sticky flag follow the registered state, so both rise the cycle after confirmation.
    assign report_valid      = (state_q == REPORT);
    assign deadlock_detected = (state_q == REPORT) || (state_q == HOLD);
    assign report_idx        = idx_q;
    assign report_ts         = rts_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_auto_parkcalc_hls_deadlock_report_unit.sv
// Directed testbench for auto_parkcalc_hls_deadlock_report_unit (NUM_MON=2, THRESHOLD=4).
module tb_auto_parkcalc_hls_deadlock_report_unit;

    logic        clock;
    logic        reset_n;
    logic [1:0]  block_sigs;
    logic        clear;
    logic        report_valid;
    logic        report_ready;
    logic [0:0]  report_idx;
    logic [31:0] report_ts;
    logic        deadlock_detected;
    logic [1:0]  state_dbg;

    int compared;
    int mismatched;

    auto_parkcalc_hls_deadlock_report_unit #(
        .NUM_MON(2), .IDX_W(1), .CNT_W(16), .THRESHOLD(4), .TS_W(32)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .block_sigs(block_sigs),
        .clear(clear),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_idx(report_idx),
        .report_ts(report_ts),
        .deadlock_detected(deadlock_detected),
        .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Leaves reset released at a falling edge, so the next cycle is cycle 0 with timestamp 0.
    task automatic doReset();
        reset_n = 1'b0; block_sigs = 2'b00; clear = 1'b0; report_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        doReset();
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got=%0h want=0", report_valid); end
        compared++; if (deadlock_detected !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_detected got=%0h want=0", deadlock_detected); end
        compared++; if (report_idx !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_idx got=%0h want=0", report_idx); end
        compared++; if (report_ts !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_ts got=%0h want=0", report_ts); end
        compared++; if (state_dbg !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_state got=%0h want=0", state_dbg); end
    endtask

    task automatic test_basic();
        doReset();
        report_ready = 1'b1; block_sigs = 2'b01;
        waitCycles(3);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_early_valid got=%0h want=0", report_valid); end
        compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("[TB] FAIL basic_armed got=%0h want=1", state_dbg); end
        waitCycles(1);
        compared++; if (report_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_valid got=%0h want=1", report_valid); end
        compared++; if (report_idx !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_idx got=%0h want=0", report_idx); end
        compared++; if (report_ts !== 32'd3) begin mismatched++; $display("[TB] FAIL basic_ts got=%0d want=3", report_ts); end
        compared++; if (deadlock_detected !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_detected got=%0h want=1", deadlock_detected); end
        block_sigs = 2'b00;
        waitCycles(1);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_valid_drop got=%0h want=0", report_valid); end
        compared++; if (state_dbg !== 2'd3) begin mismatched++; $display("[TB] FAIL basic_hold got=%0h want=3", state_dbg); end
        compared++; if (deadlock_detected !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_hold_detected got=%0h want=1", deadlock_detected); end
        compared++; if (report_ts !== 32'd3) begin mismatched++; $display("[TB] FAIL basic_hold_ts got=%0d want=3", report_ts); end
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        compared++; if (deadlock_detected !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_clear_detected got=%0h want=0", deadlock_detected); end
        compared++; if (state_dbg !== 2'd0) begin mismatched++; $display("[TB] FAIL hold_clear_state got=%0h want=0", state_dbg); end
        compared++; if (report_ts !== 32'd0) begin mismatched++; $display("[TB] FAIL hold_clear_ts got=%0d want=0", report_ts); end
    endtask

    task automatic test_dropout();
        doReset();
        report_ready = 1'b1; block_sigs = 2'b10;
        waitCycles(3);
        block_sigs = 2'b00;
        waitCycles(1);
        compared++; if (state_dbg !== 2'd0) begin mismatched++; $display("[TB] FAIL dropout_idle got=%0h want=0", state_dbg); end
        block_sigs = 2'b10;
        waitCycles(3);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL dropout_early_valid got=%0h want=0", report_valid); end
        waitCycles(1);
        compared++; if (report_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL dropout_valid got=%0h want=1", report_valid); end
        compared++; if (report_idx !== 1'b1) begin mismatched++; $display("[TB] FAIL dropout_idx got=%0h want=1", report_idx); end
        compared++; if (report_ts !== 32'd7) begin mismatched++; $display("[TB] FAIL dropout_ts got=%0d want=7", report_ts); end
        block_sigs = 2'b00;
    endtask

    task automatic test_relatch();
        doReset();
        report_ready = 1'b1; block_sigs = 2'b11;
        waitCycles(2);
        block_sigs = 2'b10;
        waitCycles(3);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL relatch_early_valid got=%0h want=0", report_valid); end
        compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("[TB] FAIL relatch_armed got=%0h want=1", state_dbg); end
        waitCycles(1);
        compared++; if (report_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL relatch_valid got=%0h want=1", report_valid); end
        compared++; if (report_idx !== 1'b1) begin mismatched++; $display("[TB] FAIL relatch_idx got=%0h want=1", report_idx); end
        compared++; if (report_ts !== 32'd5) begin mismatched++; $display("[TB] FAIL relatch_ts got=%0d want=5", report_ts); end
        block_sigs = 2'b00;
    endtask

    task automatic test_back_pressure();
        doReset();
        report_ready = 1'b0; block_sigs = 2'b01;
        waitCycles(4);
        block_sigs = 2'b10;
        for (int k = 0; k < 5; k++) begin
            clear = (k == 2);
            compared++; if (report_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid[%0d] got=%0h want=1", k, report_valid); end
            compared++; if (report_idx !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_idx[%0d] got=%0h want=0", k, report_idx); end
            compared++; if (report_ts !== 32'd3) begin mismatched++; $display("[TB] FAIL bp_ts[%0d] got=%0d want=3", k, report_ts); end
            waitCycles(1);
        end
        clear = 1'b0;
        compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("[TB] FAIL bp_still_report got=%0h want=2", state_dbg); end
        report_ready = 1'b1;
        waitCycles(1);
        report_ready = 1'b0; block_sigs = 2'b01;
        compared++; if (state_dbg !== 2'd3) begin mismatched++; $display("[TB] FAIL bp_hold got=%0h want=3", state_dbg); end
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_valid_drop got=%0h want=0", report_valid); end
        waitCycles(6);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_no_second got=%0h want=0", report_valid); end
        compared++; if (deadlock_detected !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_sticky got=%0h want=1", deadlock_detected); end
        block_sigs = 2'b00;
    endtask

    task automatic test_clear_armed();
        doReset();
        report_ready = 1'b1; block_sigs = 2'b01;
        waitCycles(3);
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        compared++; if (state_dbg !== 2'd0) begin mismatched++; $display("[TB] FAIL clear_armed_idle got=%0h want=0", state_dbg); end
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_armed_valid got=%0h want=0", report_valid); end
        block_sigs = 2'b00;
        waitCycles(3);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_armed_late got=%0h want=0", report_valid); end
        compared++; if (deadlock_detected !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_armed_detected got=%0h want=0", deadlock_detected); end
    endtask

    task automatic test_reset_mid_report();
        doReset();
        report_ready = 1'b0; block_sigs = 2'b01;
        waitCycles(4);
        compared++; if (report_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pre_valid got=%0h want=1", report_valid); end
        reset_n = 1'b0;
        waitCycles(1);
        compared++; if (report_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_valid got=%0h want=0", report_valid); end
        compared++; if (deadlock_detected !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_detected got=%0h want=0", deadlock_detected); end
        compared++; if (report_ts !== 32'd0) begin mismatched++; $display("[TB] FAIL mid_ts got=%0d want=0", report_ts); end
        compared++; if (state_dbg !== 2'd0) begin mismatched++; $display("[TB] FAIL mid_state got=%0h want=0", state_dbg); end
        reset_n = 1'b1; block_sigs = 2'b00;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_dropout();
        test_relatch();
        test_back_pressure();
        test_clear_armed();
        test_reset_mid_report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
